// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and case helper for the PS/2 Set-2 key decoder.
package ps2_pkg;

  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASC_NUL      = 8'h00;
  localparam logic [7:0] ASC_BS       = 8'h08;
  localparam logic [7:0] ASC_CR       = 8'h0D;
  localparam logic [7:0] ASC_SPACE    = 8'h20;
  localparam logic [7:0] ASC_ZERO     = 8'h30;
  localparam logic [7:0] ASC_UPPER_A  = 8'h41;
  localparam logic [7:0] ASC_CASE_OFS = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // Letters arrive from the table in uppercase; lowercase them unless upper is requested.
  function automatic logic [7:0] apply_case(input logic [7:0] base,
                                            input logic       is_letter,
                                            input logic       upper);
    apply_case = (is_letter && !upper) ? (base + ASC_CASE_OFS) : base;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Scan-byte input stream and ASCII output stream of the key decoder.
// Both streams: a transfer happens on a rising clk edge where valid && ready are both high.
interface ps2_key_decoder_if;
  logic       code_valid;
  logic [7:0] code_data;
  logic       code_ready;
  logic       out_valid;
  logic [7:0] out_ascii;
  logic       out_ready;

  modport master (
    output code_valid, code_data, out_ready,
    input  code_ready, out_valid, out_ascii
  );

  modport slave (
    input  code_valid, code_data, out_ready,
    output code_ready, out_valid, out_ascii
  );
endinterface

// File: rtl/ps2_scan_lut.sv
// Combinational Set-2 scan byte to ASCII table: digits, letters (uppercase), space, enter, backspace.
module ps2_scan_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  output logic       mapped_o,
  output logic       is_letter_o,
  output logic [7:0] base_ascii_o
);

  logic [4:0] letter_idx;
  logic       letter_hit;
  logic [3:0] digit_val;
  logic       digit_hit;

  always_comb begin
    letter_hit = 1'b1;
    letter_idx = 5'd0;
    case (code_i)
      8'h1C: letter_idx = 5'd0;
      8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;
      8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;
      8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;
      8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;
      8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;
      8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;
      8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;
      8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;
      8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;
      8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;
      8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;
      8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;
      8'h1A: letter_idx = 5'd25;
      default: letter_hit = 1'b0;
    endcase
  end

  always_comb begin
    digit_hit = 1'b1;
    digit_val = 4'd0;
    case (code_i)
      8'h45: digit_val = 4'd0;
      8'h16: digit_val = 4'd1;
      8'h1E: digit_val = 4'd2;
      8'h26: digit_val = 4'd3;
      8'h25: digit_val = 4'd4;
      8'h2E: digit_val = 4'd5;
      8'h36: digit_val = 4'd6;
      8'h3D: digit_val = 4'd7;
      8'h3E: digit_val = 4'd8;
      8'h46: digit_val = 4'd9;
      default: digit_hit = 1'b0;
    endcase
  end

  always_comb begin
    mapped_o     = 1'b1;
    is_letter_o  = 1'b0;
    base_ascii_o = ASC_NUL;
    if (letter_hit) begin
      is_letter_o  = 1'b1;
      base_ascii_o = ASC_UPPER_A + {3'b000, letter_idx};
    end else if (digit_hit) begin
      base_ascii_o = ASC_ZERO + {4'h0, digit_val};
    end else if (code_i == SC_SPACE) begin
      base_ascii_o = ASC_SPACE;
    end else if (code_i == SC_ENTER) begin
      base_ascii_o = ASC_CR;
    end else if (code_i == SC_BKSP) begin
      base_ascii_o = ASC_BS;
    end else begin
      mapped_o = 1'b0;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Stateful PS/2 Set-2 decoder: prefix FSM, shift/caps tracking, held-key repeat filter,
// and a show-ahead output FIFO of case-correct ASCII.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit REPEAT_EN  = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  ps2_key_decoder_if.slave bus,
  output logic             shift_o,
  output logic             caps_o,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output ps2_state_e       state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  ps2_state_e       state_q;
  logic             lshift_q, rshift_q, caps_q, caps_held_q;
  logic [7:0]       held_q;
  logic [CNT_W-1:0] cnt_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic       fifo_full, fifo_empty, accept, pop;
  logic       lut_mapped, lut_letter;
  logic [7:0] lut_base;
  logic       push_d;
  logic [7:0] char_d;

  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign accept     = bus.code_valid && !fifo_full;
  assign pop        = bus.out_ready && !fifo_empty;

  assign bus.code_ready = !fifo_full;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_ascii  = fifo_empty ? ASC_NUL : mem_q[rd_ptr_q];

  assign shift_o   = lshift_q | rshift_q;
  assign caps_o    = caps_q;
  assign held_code = held_q;
  assign press_cnt = cnt_q;
  assign state_o   = state_q;

  ps2_scan_lut u_lut (
    .code_i       (bus.code_data),
    .mapped_o     (lut_mapped),
    .is_letter_o  (lut_letter),
    .base_ascii_o (lut_base)
  );

  // Case uses modifier state from before this byte; a held key only re-emits with REPEAT_EN.
  always_comb begin
    push_d = 1'b0;
    char_d = apply_case(lut_base, lut_letter, shift_o ^ caps_q);
    if (accept && state_q == ST_IDLE && lut_mapped &&
        (REPEAT_EN || bus.code_data != held_q)) begin
      push_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      held_q      <= 8'h00;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            if (bus.code_data == SC_F0) begin
              state_q <= ST_BRK;
            end else if (bus.code_data == SC_E0) begin
              state_q <= ST_EXT;
            end else if (bus.code_data == SC_LSHIFT) begin
              lshift_q <= 1'b1;
            end else if (bus.code_data == SC_RSHIFT) begin
              rshift_q <= 1'b1;
            end else if (bus.code_data == SC_CAPS) begin
              // Typematic caps makes must not keep toggling the lock.
              if (!caps_held_q) caps_q <= ~caps_q;
              caps_held_q <= 1'b1;
            end else if (push_d) begin
              held_q <= bus.code_data;
            end
          end
          ST_BRK: begin
            state_q <= ST_IDLE;
            if (bus.code_data == SC_LSHIFT) lshift_q <= 1'b0;
            if (bus.code_data == SC_RSHIFT) rshift_q <= 1'b0;
            if (bus.code_data == SC_CAPS)   caps_held_q <= 1'b0;
            if (bus.code_data == held_q)    held_q <= 8'h00;
          end
          ST_EXT: begin
            state_q <= (bus.code_data == SC_F0) ? ST_EXT_BRK : ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
      if (push_d) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (push_d) begin
        mem_q[wr_ptr_q] <= char_d;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_d, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: two instances (repeat filter on/off) share the byte stream.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ps2_key_decoder_if if_a ();
  ps2_key_decoder_if if_b ();

  logic       shift_a, caps_a, shift_b, caps_b;
  logic [7:0] held_a, held_b, cnt_a, cnt_b;
  ps2_state_e state_a, state_b;

  ps2_key_decoder #(.FIFO_DEPTH(4), .REPEAT_EN(1'b0), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .bus(if_a), .shift_o(shift_a), .caps_o(caps_a),
    .held_code(held_a), .press_cnt(cnt_a), .state_o(state_a)
  );

  ps2_key_decoder #(.FIFO_DEPTH(4), .REPEAT_EN(1'b1), .CNT_W(8)) dut_rep (
    .clk(clk), .clrn(clrn), .bus(if_b), .shift_o(shift_b), .caps_o(caps_b),
    .held_code(held_b), .press_cnt(cnt_b), .state_o(state_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];

  // Monitor: a pop happens at the next rising edge when valid && ready hold at the falling edge.
  always @(negedge clk) begin
    if (clrn && if_a.out_valid && if_a.out_ready) got_a.push_back(if_a.out_ascii);
    if (clrn && if_b.out_valid && if_b.out_ready) got_b.push_back(if_b.out_ascii);
  end

  task automatic set_inputs(input logic v, input logic [7:0] d, input logic rdy);
    if_a.code_valid = v; if_a.code_data = d; if_a.out_ready = rdy;
    if_b.code_valid = v; if_b.code_data = d; if_b.out_ready = rdy;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    set_inputs(1'b0, 8'h00, 1'b1);
    clrn = 1'b0;
    wait_cycles(2);
    got_a.delete(); got_b.delete(); exp_q.delete(); exp_b_q.delete();
    clrn = 1'b1;
    wait_cycles(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if_a.code_valid = 1'b1; if_a.code_data = b;
    if_b.code_valid = 1'b1; if_b.code_data = b;
    while (!(if_a.code_ready && if_b.code_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL send_timeout byte=%02h ready never seen", b);
    end
    @(posedge clk); #1;
    if_a.code_valid = 1'b0; if_b.code_valid = 1'b0;
  endtask

  task automatic test_reset();
    set_inputs(1'b0, 8'h00, 1'b1);
    clrn = 1'b0;
    #1;
    n_checks++; if (if_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", if_a.out_valid); end
    n_checks++; if (if_a.out_ascii !== 8'h00) begin n_fail++; $display("FAIL rst_out_ascii got=%02h exp=00", if_a.out_ascii); end
    n_checks++; if (shift_a !== 1'b0 || caps_a !== 1'b0) begin n_fail++; $display("FAIL rst_mods got=%b%b exp=00", shift_a, caps_a); end
    n_checks++; if (held_a !== 8'h00) begin n_fail++; $display("FAIL rst_held got=%02h exp=00", held_a); end
    n_checks++; if (cnt_a !== 8'h00) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", cnt_a); end
    n_checks++; if (state_a !== ST_IDLE) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state_a); end
    do_reset();
    n_checks++; if (if_a.code_ready !== 1'b1) begin n_fail++; $display("FAIL rst_code_ready got=%b exp=1", if_a.code_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    send_byte(8'h1C);
    n_checks++; if (held_a !== 8'h1C) begin n_fail++; $display("FAIL basic_held_make got=%02h exp=1c", held_a); end
    send_byte(SC_F0); send_byte(8'h1C);
    n_checks++; if (held_a !== 8'h00) begin n_fail++; $display("FAIL basic_held_break got=%02h exp=00", held_a); end
    wait_cycles(3);
    exp_q.push_back(8'h61);
    n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      n_checks++; if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_char[%0d] got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
    n_checks++; if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL basic_press_cnt got=%0d exp=1", cnt_a); end
  endtask

  task automatic test_shift();
    do_reset();
    send_byte(SC_LSHIFT);
    n_checks++; if (shift_a !== 1'b1) begin n_fail++; $display("FAIL shift_on got=%b exp=1", shift_a); end
    send_byte(8'h1C); send_byte(SC_F0); send_byte(8'h1C);
    send_byte(SC_F0); send_byte(SC_LSHIFT);
    n_checks++; if (shift_a !== 1'b0) begin n_fail++; $display("FAIL shift_off got=%b exp=0", shift_a); end
    send_byte(SC_RSHIFT);
    n_checks++; if (shift_a !== 1'b1) begin n_fail++; $display("FAIL rshift_on got=%b exp=1", shift_a); end
    send_byte(SC_F0); send_byte(SC_RSHIFT);
    send_byte(8'h1C);
    wait_cycles(3);
    exp_q.push_back(8'h41); exp_q.push_back(8'h61);
    n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL shift_count got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      n_checks++; if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL shift_char[%0d] got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_caps();
    do_reset();
    send_byte(SC_CAPS);
    n_checks++; if (caps_a !== 1'b1) begin n_fail++; $display("FAIL caps_on got=%b exp=1", caps_a); end
    send_byte(SC_F0); send_byte(SC_CAPS);
    send_byte(8'h1C); send_byte(SC_F0); send_byte(8'h1C);
    send_byte(SC_LSHIFT); send_byte(8'h1C);
    send_byte(SC_F0); send_byte(8'h1C); send_byte(SC_F0); send_byte(SC_LSHIFT);
    send_byte(8'h16);
    send_byte(SC_CAPS); send_byte(SC_CAPS);
    n_checks++; if (caps_a !== 1'b0) begin n_fail++; $display("FAIL caps_toggle_once got=%b exp=0", caps_a); end
    send_byte(SC_F0); send_byte(SC_CAPS);
    send_byte(SC_SPACE); send_byte(SC_ENTER); send_byte(SC_BKSP);
    wait_cycles(3);
    exp_q = '{8'h41, 8'h61, 8'h31, 8'h20, 8'h0D, 8'h08};
    n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL caps_count got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      n_checks++; if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL caps_char[%0d] got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_repeat();
    do_reset();
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(SC_F0); send_byte(8'h1C);
    wait_cycles(3);
    exp_q = '{8'h61};
    exp_b_q = '{8'h61, 8'h61, 8'h61};
    n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL rep_off_count got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    n_checks++; if (got_b.size() != exp_b_q.size()) begin n_fail++; $display("FAIL rep_on_count got=%0d exp=%0d", got_b.size(), exp_b_q.size()); end
    for (int i = 0; i < exp_b_q.size() && i < got_b.size(); i++) begin
      n_checks++; if (got_b[i] !== exp_b_q[i]) begin n_fail++; $display("FAIL rep_on_char[%0d] got=%02h exp=%02h", i, got_b[i], exp_b_q[i]); end
    end
    n_checks++; if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL rep_off_cnt got=%0d exp=1", cnt_a); end
    n_checks++; if (cnt_b !== 8'd3) begin n_fail++; $display("FAIL rep_on_cnt got=%0d exp=3", cnt_b); end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(SC_E0);
    n_checks++; if (state_a !== ST_EXT) begin n_fail++; $display("FAIL ext_state got=%0d exp=2", state_a); end
    send_byte(8'h75);
    n_checks++; if (state_a !== ST_IDLE) begin n_fail++; $display("FAIL ext_idle1 got=%0d exp=0", state_a); end
    send_byte(SC_E0); send_byte(SC_F0);
    n_checks++; if (state_a !== ST_EXT_BRK) begin n_fail++; $display("FAIL ext_brk_state got=%0d exp=3", state_a); end
    send_byte(8'h75);
    n_checks++; if (state_a !== ST_IDLE) begin n_fail++; $display("FAIL ext_idle2 got=%0d exp=0", state_a); end
    send_byte(SC_E0); send_byte(SC_LSHIFT);
    n_checks++; if (shift_a !== 1'b0) begin n_fail++; $display("FAIL ext_fake_shift got=%b exp=0", shift_a); end
    send_byte(8'h77);
    send_byte(8'h16);
    wait_cycles(3);
    exp_q = '{8'h31};
    n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL ext_count got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      n_checks++; if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL ext_char[%0d] got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_a.out_ready = 1'b0; if_b.out_ready = 1'b0;
    send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21);
    n_checks++; if (if_a.code_ready !== 1'b1) begin n_fail++; $display("FAIL fifo_ready_3 got=%b exp=1", if_a.code_ready); end
    send_byte(8'h23);
    n_checks++; if (if_a.code_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full got=%b exp=0", if_a.code_ready); end
    if_a.code_valid = 1'b1; if_a.code_data = 8'h24;
    if_b.code_valid = 1'b1; if_b.code_data = 8'h24;
    wait_cycles(3);
    n_checks++; if (cnt_a !== 8'd4) begin n_fail++; $display("FAIL fifo_stall_cnt got=%0d exp=4", cnt_a); end
    n_checks++; if (if_a.out_ascii !== 8'h61 || if_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL fifo_head got=%02h/%b exp=61/1", if_a.out_ascii, if_a.out_valid); end
    if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
    wait_cycles(1);
    if_a.out_ready = 1'b0; if_b.out_ready = 1'b0;
    n_checks++; if (if_a.code_ready !== 1'b1 || cnt_a !== 8'd4) begin n_fail++; $display("FAIL fifo_after_pop got=%b/%0d exp=1/4", if_a.code_ready, cnt_a); end
    wait_cycles(1);
    if_a.code_valid = 1'b0; if_b.code_valid = 1'b0;
    n_checks++; if (cnt_a !== 8'd5 || if_a.code_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_fifth got=%0d/%b exp=5/0", cnt_a, if_a.code_ready); end
    if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
    wait_cycles(8);
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL fifo_count got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      n_checks++; if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL fifo_char[%0d] got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
    n_checks++; if (if_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_drained got=%b exp=0", if_a.out_valid); end
  endtask

  task automatic test_midreset();
    do_reset();
    if_a.out_ready = 1'b0; if_b.out_ready = 1'b0;
    send_byte(SC_LSHIFT); send_byte(SC_CAPS); send_byte(8'h1C); send_byte(SC_F0);
    n_checks++; if (state_a !== ST_BRK || if_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got=%0d/%b exp=1/1", state_a, if_a.out_valid); end
    clrn = 1'b0;
    #1;
    n_checks++; if (state_a !== ST_IDLE || if_a.out_valid !== 1'b0 || if_a.out_ascii !== 8'h00) begin
      n_fail++; $display("FAIL mid_rst_fsm got=%0d/%b/%02h exp=0/0/00", state_a, if_a.out_valid, if_a.out_ascii);
    end
    n_checks++; if (shift_a !== 1'b0 || caps_a !== 1'b0 || held_a !== 8'h00 || cnt_a !== 8'd0) begin
      n_fail++; $display("FAIL mid_rst_regs got=%b/%b/%02h/%0d exp=0/0/00/0", shift_a, caps_a, held_a, cnt_a);
    end
    wait_cycles(1);
    got_a.delete(); got_b.delete();
    clrn = 1'b1;
    if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
    wait_cycles(1);
    send_byte(8'h1C);
    wait_cycles(3);
    exp_q = '{8'h61};
    n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_post_count got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      n_checks++; if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_post_char[%0d] got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    set_inputs(1'b0, 8'h00, 1'b1);
    wait_cycles(2);
    test_reset();
    test_basic();
    test_shift();
    test_caps();
    test_repeat();
    test_extended();
    test_back_to_back();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Stateful PS/2 Set-2 scan-code decoder between the PS/2 byte receiver and the character consumer (UART/terminal/VGA text path). Tracks break (F0) and extended (E0) prefixes, shift/caps-lock state and the currently held key. Suppresses typematic repeats unless configured otherwise. Emits case-correct ASCII through a parametrised show-ahead FIFO with valid/ready handshakes on both sides.

## Interface
- FIFO_DEPTH, 8, output FIFO entries; power of two, ≥2
- REPEAT_EN, 0, 1 = every make byte of a printable key is emitted; 0 = repeats of the held key are suppressed
- CNT_W, 8, width of press_cnt
- clk  in  1  sole clock, rising edge
- clrn  in  1  asynchronous, active-low reset
- code_valid  in  1  scan byte offered
- code_data  in  8  scan byte
- code_ready  out  1  byte accepted when code_valid && code_ready at clk edge
- out_valid  out  1  FIFO non-empty
- out_ascii  out  8  FIFO head (show-ahead)
- out_ready  in  1  pop when out_valid && out_ready
- shift_o  out  1  left or right shift held
- caps_o  out  1  caps-lock latched
- held_code  out  8  last printable make code not yet released; 0x00 if none
- press_cnt  out  CNT_W  count of characters pushed; wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). One transition per accepted byte.
- IDLE:
  - F0 → BRK; E0 → EXT.
  - 0x12/0x59 → set lshift/rshift.
  - 0x58 → toggle caps only if caps_held=0, then set caps_held.
  - Any other byte is looked up:
    - mapped, and (REPEAT_EN or byte≠held_code) → push char, held_code←byte.
    - mapped repeat with REPEAT_EN=0 → no push.
    - unmapped → ignored, held_code unchanged.
- BRK: any byte → IDLE, no push.
  - 0x12/0x59 → clear that shift.
  - 0x58 → clear caps_held.
  - byte==held_code → held_code←0.
  - Break of any other key leaves held_code unchanged.
- EXT: F0 → EXT_BRK; any other byte → IDLE, ignored (includes fake shift E0 12).
- EXT_BRK: any byte → IDLE, ignored.
- Mapping:
  - Digits 0–9 → 0x30–0x39, unaffected by shift/caps.
  - Letters A–Z → 0x41–0x5A when shift_o XOR caps_o, else +0x20.
  - 0x29 → 0x20; 0x5A → 0x0D; 0x66 → 0x08.
  - A new printable make while another key is held replaces held_code.
- press_cnt increments on every push.

## Timing
- Reset values: state IDLE; out_valid 0, out_ascii 0x00, shift_o 0, caps_o 0, held_code 0x00, press_cnt 0, FIFO empty. code_ready is 1 once reset is deasserted.
- code_ready = !fifo_full, combinational from occupancy only. A pop in the same cycle does not raise it; a full FIFO stalls every byte, including prefixes.
- Latency: character visible on out_valid/out_ascii the cycle after the accepted byte. shift_o, caps_o and held_code update on that same edge.
- Simultaneous push and pop when not full: occupancy unchanged, order preserved. Pop when empty: no effect.
- The lookup uses shift/caps state from before the current byte.
- Pointers wrap modulo FIFO_DEPTH. A full/empty distinction is required (extra pointer bit or counter).
- Asserting clrn mid-sequence discards any pending prefix, FIFO contents and modifier state immediately.

## Structure
- Shared package ps2_pkg:
  - scan-code constants: F0, E0, LSHIFT 0x12, RSHIFT 0x59, CAPS 0x58, SPACE, ENTER, BKSP
  - ASCII constants
  - FSM state enum
- One sub-module, ps2_scan_lut: combinational scan byte → {mapped, is_letter, base_ascii (uppercase)}. Includes space/enter/backspace.
- FSM, modifier registers, counter and FIFO are inline.

## Test plan
- 1C, then F0 1C → single 0x61; held_code 0x1C then 0x00; press_cnt 1.
- 12, 1C, F0 1C, F0 12, 1C → 0x41 then 0x61; shift_o high only between 12 and F0 12.
- 58, F0 58, 1C, 12, 1C → 0x41, then 0x61 (caps XOR shift); 58 58 without release toggles caps once.
- 1C 1C 1C F0 1C → one 0x61 with REPEAT_EN=0; three 0x61 with REPEAT_EN=1.
- E0 75, E0 F0 75, 16 → only 0x31; state IDLE after each sequence.
- FIFO_DEPTH=4, out_ready=0, five letter makes → code_ready low after 4th, 5th stalls. Pop one → 5th accepted next edge; output order intact; press_cnt 5. clrn pulse → all outputs at reset values.
